// File: rtl/dds_spi_frame_master.sv
// dds_spi_frame_master: serialises a DDS FREQ0/PHASE0/waveform configuration into five 16-bit SPI frames
// ACLK/ARESET: clock and asynchronous active-high reset
// cfg_valid/cfg_ready/cfg_freq/cfg_phase/cfg_wave: configuration handshake from the register file
// SCLK/FSYNC/SDATA: DDS pins (CPOL=1, FSYNC active low, MSB first)
// busy/frame_idx/done: status and end-of-transaction pulse
module dds_spi_frame_master #(
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [27:0] cfg_freq,
  input  logic [11:0] cfg_phase,
  input  logic [1:0]  cfg_wave,
  output logic        SCLK,
  output logic        FSYNC,
  output logic        SDATA,
  output logic        busy,
  output logic [2:0]  frame_idx,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(FRAME_GAP - 1);
  state_t      state, state_n;
  logic [7:0]  half_cnt, half_n, gap_cnt, gap_n;
  logic [3:0]  bit_cnt, bit_n;
  logic [2:0]  frame_n;
  logic [15:0] sr, sr_n, wbits, word;
  logic [27:0] freq;
  logic [11:0] phase;
  logic [1:0]  wave;
  logic        sclk_n, fsync_n, sdata_n, done_n, accept, frame_end, gap_end;

  assign accept = cfg_valid && cfg_ready;
  assign busy   = state != IDLE;
  assign wbits  = wave == 2'b01 ? 16'h0002 : wave == 2'b10 ? 16'h0028 : 16'h0000;
  assign word   = frame_idx == 3'd0 ? 16'h2100 | wbits :
                  frame_idx == 3'd1 ? {2'b01, freq[13:0]} :
                  frame_idx == 3'd2 ? {2'b01, freq[27:14]} :
                  frame_idx == 3'd3 ? {4'b1100, phase} : 16'h2000 | wbits;

  // SHIFT spends its first cycle with FSYNC still high loading the word; that
  // cycle doubles as the last FSYNC-high cycle of the inter-frame gap, so the
  // GAP state itself only needs FRAME_GAP-1 cycles.
  always_comb begin
    state_n   = state;
    half_n    = half_cnt;
    bit_n     = bit_cnt;
    gap_n     = gap_cnt;
    frame_n   = frame_idx;
    sr_n      = sr;
    sclk_n    = SCLK;
    fsync_n   = FSYNC;
    sdata_n   = SDATA;
    done_n    = 1'b0;
    frame_end = 1'b0;
    gap_end   = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        state_n = SHIFT;
        frame_n = 3'd0;
      end
      SHIFT: if (FSYNC) begin
        fsync_n = 1'b0;
        sdata_n = word[15];
        sr_n    = {word[14:0], 1'b0};
        half_n  = '0;
        bit_n   = '0;
      end else if (half_cnt == DIV_LAST) begin
        half_n = '0;
        sclk_n = !SCLK;
        if (!SCLK) begin
          if (bit_cnt == 4'd15) begin
            fsync_n   = 1'b1;
            sdata_n   = 1'b0;
            frame_end = 1'b1;
          end else begin
            bit_n   = bit_cnt + 4'd1;
            sdata_n = sr[15];
            sr_n    = {sr[14:0], 1'b0};
          end
        end
      end else begin
        half_n = half_cnt + 8'd1;
      end
      GAP: if (gap_cnt == GAP_LAST) gap_end = 1'b1;
      else gap_n = gap_cnt + 8'd1;
      default: state_n = IDLE;
    endcase
    if (frame_end && FRAME_GAP > 1) begin
      state_n = GAP;
      gap_n   = 8'd1;
    end
    if (gap_end || (frame_end && FRAME_GAP == 1)) begin
      state_n = frame_idx == 3'd4 ? IDLE : SHIFT;
      frame_n = frame_idx == 3'd4 ? 3'd0 : frame_idx + 3'd1;
      done_n  = frame_idx == 3'd4;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      frame_idx <= '0;
      sr        <= '0;
      freq      <= '0;
      phase     <= '0;
      wave      <= '0;
      SCLK      <= 1'b1;
      FSYNC     <= 1'b1;
      SDATA     <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_n;
      half_cnt  <= half_n;
      bit_cnt   <= bit_n;
      gap_cnt   <= gap_n;
      frame_idx <= frame_n;
      sr        <= sr_n;
      SCLK      <= sclk_n;
      FSYNC     <= fsync_n;
      SDATA     <= sdata_n;
      done      <= done_n;
      cfg_ready <= state_n == IDLE;
      if (accept) begin
        freq  <= cfg_freq;
        phase <= cfg_phase;
        wave  <= cfg_wave;
      end
    end
  end
endmodule

// File: tb/tb_dds_spi_frame_master.sv
// tb_dds_spi_frame_master: scoreboard bench decoding the SPI pins against a frame-level model
module tb_dds_spi_frame_master;
  localparam int CD = 2;
  localparam int FG = 2;
  localparam int PERIOD = 32 * CD + FG;

  logic        ACLK = 1'b0, ARESET = 1'b1, cfg_valid = 1'b0;
  logic [27:0] cfg_freq = '0;
  logic [11:0] cfg_phase = '0;
  logic [1:0]  cfg_wave = '0;
  logic        cfg_ready, SCLK, FSYNC, SDATA, busy, done;
  logic [2:0]  frame_idx;

  int vectors = 0, miscompares = 0, cyc = 0;
  int done_cnt = 0, last_done = -1, last_acc = -1, falls = 0;

  typedef struct {logic [15:0] word; int idx;} frame_t;
  frame_t exp_q[$];
  int     done_q[$];

  dds_spi_frame_master #(.CLK_DIV(CD), .FRAME_GAP(FG)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_wave(cfg_wave),
    .SCLK(SCLK), .FSYNC(FSYNC), .SDATA(SDATA), .busy(busy),
    .frame_idx(frame_idx), .done(done)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Frame contents straight from the DDS programming rules, plus done time.
  function automatic void expect_txn(input logic [27:0] f, input logic [11:0] p,
                                     input logic [1:0] w, input int acc);
    logic [15:0] wb;
    logic [15:0] fr [5];
    frame_t e;
    wb = w == 2'd1 ? 16'h0002 : w == 2'd2 ? 16'h0028 : 16'h0000;
    fr[0] = 16'h2100 | wb;
    fr[1] = 16'h4000 | 16'(f % 28'd16384);
    fr[2] = 16'h4000 | 16'(f / 28'd16384);
    fr[3] = 16'hC000 | 16'(p);
    fr[4] = 16'h2000 | wb;
    for (int i = 0; i < 5; i++) begin
      e.word = fr[i];
      e.idx  = i;
      exp_q.push_back(e);
    end
    done_q.push_back(acc + 5 * PERIOD);
  endfunction

  logic        fs_p = 1'b1, sc_p = 1'b1, sd_p = 1'b0, in_frame = 1'b0, stable = 1'b1;
  logic [15:0] word = '0;
  int          f_cyc = 0, last_fall = 0, last_chg = 0, fidx = 0;

  always @(negedge ACLK) begin
    if (ARESET) begin
      exp_q.delete();
      done_q.delete();
      in_frame = 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        last_acc = cyc + 1;
        expect_txn(cfg_freq, cfg_phase, cfg_wave, cyc + 1);
      end
      if (done) begin
        done_cnt++;
        last_done = cyc;
        chk("done expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) chk("done cycle", cyc, done_q.pop_front());
      end
      if (fs_p && !FSYNC) begin
        in_frame  = 1'b1;
        f_cyc     = cyc;
        last_chg  = cyc;
        last_fall = -1000;
        falls     = 0;
        word      = '0;
        stable    = 1'b1;
        fidx      = frame_idx;
      end else if (!fs_p && FSYNC && in_frame) begin
        frame_t e;
        in_frame = 1'b0;
        chk("fsync low width", cyc - f_cyc, 32 * CD);
        chk("sclk falls per frame", falls, 16);
        chk("sdata stable around sclk fall", stable, 1);
        chk("frame expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame word", word, e.word);
          chk("frame idx", fidx, e.idx);
        end
      end else if (FSYNC) begin
        chk("sclk quiet while fsync high", SCLK, sc_p);
      end else if (in_frame) begin
        if (sc_p && !SCLK) begin
          falls++;
          word = {word[14:0], SDATA};
          if (cyc - last_chg < CD) stable = 1'b0;
          last_fall = cyc;
        end
        if (SDATA != sd_p) begin
          if (cyc - last_fall < CD) stable = 1'b0;
          last_chg = cyc;
        end
      end
    end
    fs_p = FSYNC;
    sc_p = SCLK;
    sd_p = SDATA;
  end

  task automatic wait_accept();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge ACLK);
      if (cfg_ready) break;
    end
    chk("accept within budget", n < 2000, 1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge ACLK);
      if (!busy) break;
    end
    chk("idle within budget", n < 2000, 1);
  endtask

  task automatic send(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    @(posedge ACLK);
    #1;
    cfg_valid = 1'b1;
    cfg_freq  = f;
    cfg_phase = p;
    cfg_wave  = w;
    wait_accept();
    cfg_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge ACLK);
    #2 ARESET = 1'b0;
    #1 chk("ready low until first edge", cfg_ready, 0);
    @(posedge ACLK);
    #1 chk("ready after reset release", cfg_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, n;
    repeat (3) @(posedge ACLK);
    #1 chk("reset outputs", {SCLK, FSYNC, SDATA, busy, done, frame_idx, cfg_ready}, 9'h180);
    release_reset();
    send(28'h0A3D70A, 12'h123, 2'd0);
    wait_idle();
    send(28'h0000000, 12'h000, 2'd2);
    wait_idle();
    send(28'hFFFFFFF, 12'hFFF, 2'd1);
    wait_idle();
    send(28'($urandom), 12'($urandom), 2'd3);
    wait_idle();
    repeat (6) begin
      repeat ($urandom_range(0, 5)) @(posedge ACLK);
      send(28'($urandom), 12'($urandom), 2'($urandom));
      wait_idle();
    end
    d0 = done_cnt;
    @(posedge ACLK);
    #1;
    cfg_valid = 1'b1;
    cfg_freq  = 28'($urandom);
    cfg_phase = 12'($urandom);
    cfg_wave  = 2'd1;
    wait_accept();
    cfg_freq  = 28'($urandom);
    cfg_phase = 12'($urandom);
    cfg_wave  = 2'd2;
    repeat (100) @(posedge ACLK);
    #1 cfg_freq = 28'($urandom);
    wait_accept();
    chk("b2b accept on ready rise", last_acc, last_done + 1);
    cfg_valid = 1'b0;
    wait_idle();
    chk("b2b done pulses", done_cnt - d0, 2);
    send(28'($urandom), 12'($urandom), 2'($urandom));
    for (n = 0; n < 2000; n++) begin
      @(negedge ACLK);
      #1;
      if (frame_idx == 3'd2 && falls == 8 && !FSYNC) break;
    end
    chk("reached frame 2 bit 7", n < 2000, 1);
    #1 ARESET = 1'b1;
    #1 chk("async reset mid-frame", {FSYNC, SCLK, busy, SDATA, done, frame_idx}, 8'hC0);
    repeat (2) @(posedge ACLK);
    release_reset();
    chk("scoreboard flushed by reset", exp_q.size(), 0);
    send(28'($urandom), 12'($urandom), 2'($urandom));
    wait_idle();
    repeat (5) @(posedge ACLK);
    chk("leftover frames", exp_q.size(), 0);
    chk("leftover dones", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
